// File: rtl/tsv_ser_link_pkg.sv
// tsv_link_pkg: shared FSM types and helpers for the TSV serial link.
package tsv_link_pkg;
  localparam int PAR_MAX_W = 1024;
  typedef enum logic {TX_IDLE, SEND} tx_state_e;
  typedef enum logic {RX_IDLE, COLLECT} rx_state_e;
  function automatic int beats(input int data_w, input int tsv_w);
    return (data_w + tsv_w - 1) / tsv_w;
  endfunction
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/tsv_ser_link_if.sv
// tsv_ser_link_if: one direction of TSV lanes (data, valid, frame, parity).
interface tsv_ser_link_if #(
  parameter int TSV_W = 8
);
  logic [TSV_W-1:0] lane;
  logic vld;
  logic frame;
  logic par;
  modport master(output lane, vld, frame, par);
  modport slave(input lane, vld, frame, par);
endinterface

// File: rtl/tsv_ser_rx.sv
// tsv_ser_rx: reassembles words from incoming TSV beats and counts link errors.
module tsv_ser_rx
  import tsv_link_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TSV_W = 8,
  parameter int ERR_W = 8
) (
  input  logic              clk1,
  input  logic              rst1,
  tsv_ser_link_if.slave     up,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
);
  localparam int BEATS = beats(DATA_W, TSV_W);
  localparam int BCNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PAD_W = BEATS * TSV_W;
  rx_state_e state, state_nx;
  logic [BCNT_W-1:0] rcnt, rcnt_nx;
  logic [PAD_W-1:0] acc, acc_nx;
  logic perr, perr_nx, bad, ferr, done;
  logic [ERR_W:0] sum;
  assign bad = even_par(PAR_MAX_W'(up.lane)) != up.par;
  always_comb begin
    state_nx = state;
    rcnt_nx = rcnt;
    acc_nx = acc;
    perr_nx = perr;
    ferr = 1'b0;
    done = 1'b0;
    if (up.vld && up.frame) begin
      ferr = state == COLLECT;
      acc_nx = PAD_W'(up.lane);
      perr_nx = bad;
      done = BEATS == 1;
      state_nx = BEATS == 1 ? RX_IDLE : COLLECT;
      rcnt_nx = BEATS == 1 ? '0 : BCNT_W'(1);
    end else if (up.vld && state == RX_IDLE) begin
      ferr = 1'b1;
    end else if (up.vld) begin
      acc_nx[rcnt*TSV_W +: TSV_W] = up.lane;
      perr_nx = perr | bad;
      done = rcnt == BCNT_W'(BEATS - 1);
      state_nx = done ? RX_IDLE : COLLECT;
      rcnt_nx = done ? '0 : rcnt + 1'b1;
    end
  end
  // a parity word strobe and a frame error in the same cycle add two
  assign sum = {1'b0, err_cnt} + {{ERR_W{1'b0}}, rx_valid & rx_perr} + {{ERR_W{1'b0}}, ferr};
  always_ff @(posedge clk1) begin
    if (rst1) begin
      state <= RX_IDLE;
      rcnt <= '0;
      acc <= '0;
      perr <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_perr <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      rcnt <= rcnt_nx;
      acc <= acc_nx;
      perr <= perr_nx;
      rx_valid <= done;
      rx_perr <= done & perr_nx;
      if (done) rx_data <= acc_nx[DATA_W-1:0];
      err_cnt <= err_clr ? '0 : sum[ERR_W] ? '1 : sum[ERR_W-1:0];
    end
  end
endmodule

// File: rtl/tsv_ser_link.sv
// tsv_ser_link: serializes a DATA_W word over TSV_W data TSVs and reassembles the return direction.
module tsv_ser_link
  import tsv_link_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TSV_W = 8,
  parameter int ERR_W = 8
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  tsv_ser_link_if.master    dn,
  tsv_ser_link_if.slave     up,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              err_clr
);
  localparam int BEATS = beats(DATA_W, TSV_W);
  localparam int BCNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PAD_W = BEATS * TSV_W;
  tx_state_e state, state_nx;
  logic [BCNT_W-1:0] bcnt, bcnt_nx;
  logic [PAD_W-1:0] sh, sh_nx, pad;
  logic [TSV_W-1:0] lane_nx;
  logic vld_nx, frame_nx, last, accept;
  assign pad = PAD_W'(tx_data);
  assign last = bcnt == BCNT_W'(BEATS - 1);
  assign tx_ready = state == TX_IDLE || (state == SEND && last);
  assign accept = tx_valid && tx_ready;
  // sh holds the beats not yet on the lanes, LSB chunk first
  always_comb begin
    state_nx = state;
    bcnt_nx = bcnt;
    sh_nx = sh;
    lane_nx = '0;
    vld_nx = 1'b0;
    frame_nx = 1'b0;
    if (accept) begin
      state_nx = SEND;
      bcnt_nx = '0;
      sh_nx = pad >> TSV_W;
      lane_nx = pad[TSV_W-1:0];
      vld_nx = 1'b1;
      frame_nx = 1'b1;
    end else if (state == SEND && !last) begin
      bcnt_nx = bcnt + 1'b1;
      sh_nx = sh >> TSV_W;
      lane_nx = sh[TSV_W-1:0];
      vld_nx = 1'b1;
    end else if (state == SEND) begin
      state_nx = TX_IDLE;
      bcnt_nx = '0;
    end
  end
  always_ff @(posedge clk1) begin
    if (rst1) begin
      state <= TX_IDLE;
      bcnt <= '0;
      sh <= '0;
      dn.lane <= '0;
      dn.vld <= 1'b0;
      dn.frame <= 1'b0;
      dn.par <= 1'b0;
    end else begin
      state <= state_nx;
      bcnt <= bcnt_nx;
      sh <= sh_nx;
      dn.lane <= lane_nx;
      dn.vld <= vld_nx;
      dn.frame <= frame_nx;
      dn.par <= even_par(PAR_MAX_W'(lane_nx));
    end
  end
  tsv_ser_rx #(
    .DATA_W(DATA_W),
    .TSV_W(TSV_W),
    .ERR_W(ERR_W)
  ) u_rx (
    .clk1(clk1),
    .rst1(rst1),
    .up(up),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_perr(rx_perr),
    .err_cnt(err_cnt),
    .err_clr(err_clr)
  );
endmodule

// File: tb/tb_tsv_ser_link.sv
// tb_tsv_ser_link: directed checks of a 32/8 loopback link and a 20/8 link with a 2-bit error counter.
module tb_tsv_ser_link;
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;
  logic rst_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_perr_a, err_clr_a;
  logic [31:0] tx_data_a, rx_data_a;
  logic [7:0] err_cnt_a;
  logic rst_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_perr_b, err_clr_b;
  logic [19:0] tx_data_b, rx_data_b;
  logic [1:0] err_cnt_b;
  logic lb_b, m_vld, m_frame, m_par;
  logic [7:0] m_lane;
  int checks = 0, fails = 0, cnt_a = 0, cnt_b = 0, n0;
  tsv_ser_link_if #(.TSV_W(8)) dn_a(), up_a(), dn_b(), up_b();
  assign up_a.lane = dn_a.lane;
  assign up_a.vld = dn_a.vld;
  assign up_a.frame = dn_a.frame;
  assign up_a.par = dn_a.par;
  assign up_b.lane = lb_b ? dn_b.lane : m_lane;
  assign up_b.vld = lb_b ? dn_b.vld : m_vld;
  assign up_b.frame = lb_b ? dn_b.frame : m_frame;
  assign up_b.par = lb_b ? dn_b.par : m_par;
  tsv_ser_link #(.DATA_W(32), .TSV_W(8), .ERR_W(8)) dut_a (
    .clk1(clk1), .rst1(rst_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
    .dn(dn_a), .up(up_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_perr(rx_perr_a),
    .err_cnt(err_cnt_a), .err_clr(err_clr_a)
  );
  tsv_ser_link #(.DATA_W(20), .TSV_W(8), .ERR_W(2)) dut_b (
    .clk1(clk1), .rst1(rst_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
    .dn(dn_b), .up(up_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_perr(rx_perr_b),
    .err_cnt(err_cnt_b), .err_clr(err_clr_b)
  );
  always @(posedge clk1) begin
    if (rx_valid_a) cnt_a++;
    if (rx_valid_b) cnt_b++;
  end
  typedef struct packed {
    logic [31:0] word;
    logic [3:0] par;
  } vec_t;
  vec_t vt [5];
  logic [7:0] b_lane [3];
  logic b_par [3];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk1);
    @(negedge clk1);
  endtask
  task automatic beat(input logic [7:0] l, input logic f, input logic flip);
    m_vld = 1'b1;
    m_lane = l;
    m_frame = f;
    m_par = (^l) ^ flip;
    tick;
    m_vld = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{32'hDEADBEEF, 4'b0101};
    vt[1] = '{32'h00000001, 4'b0001};
    vt[2] = '{32'hFF7F0180, 4'b0111};
    vt[3] = '{32'h00000000, 4'b0000};
    vt[4] = '{32'h80C0E0F1, 4'b1011};
    b_lane = '{8'hDE, 8'hBC, 8'h0A};
    b_par = '{1'b0, 1'b1, 1'b0};
    rst_a = 1'b1; rst_b = 1'b1;
    tx_valid_a = 1'b0; tx_data_a = '0; err_clr_a = 1'b0;
    tx_valid_b = 1'b0; tx_data_b = '0; err_clr_b = 1'b0;
    lb_b = 1'b1; m_vld = 1'b0; m_lane = '0; m_frame = 1'b0; m_par = 1'b0;
    @(negedge clk1);
    tick;
    tick;
    rst_a = 1'b0; rst_b = 1'b0;
    tick;
    chk("rst_a_ready", tx_ready_a, 1);
    chk("rst_a_dn", {dn_a.lane, dn_a.vld, dn_a.frame, dn_a.par}, 0);
    chk("rst_a_rx", {rx_valid_a, rx_data_a, rx_perr_a, err_cnt_a}, 0);
    chk("rst_b_ready", tx_ready_b, 1);
    chk("rst_b_dn", {dn_b.lane, dn_b.vld, dn_b.frame, dn_b.par}, 0);
    chk("rst_b_rx", {rx_valid_b, rx_data_b, rx_perr_b, err_cnt_b}, 0);
    for (int v = 0; v < 5; v++) begin
      chk("a_ready_idle", tx_ready_a, 1);
      tx_valid_a = 1'b1;
      tx_data_a = vt[v].word;
      tick;
      tx_valid_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("a_lane", dn_a.lane, vt[v].word[k*8 +: 8]);
        chk("a_vld", dn_a.vld, 1);
        chk("a_frame", dn_a.frame, k == 0);
        chk("a_par", dn_a.par, vt[v].par[k]);
        chk("a_ready_beat", tx_ready_a, k == 3);
        chk("a_rx_early", rx_valid_a, 0);
        tick;
      end
      chk("a_rx_valid", rx_valid_a, 1);
      chk("a_rx_data", rx_data_a, vt[v].word);
      chk("a_rx_perr", rx_perr_a, 0);
      chk("a_dn_idle", dn_a.vld, 0);
      tick;
      chk("a_rx_strobe", rx_valid_a, 0);
      chk("a_rx_hold", rx_data_a, vt[v].word);
    end
    tx_valid_a = 1'b1;
    tx_data_a = 32'h11223344;
    tick;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        chk("b2b_lane", dn_a.lane, i < 4 ? 8'(32'h11223344 >> (i * 8)) : 8'(32'h55667788 >> ((i - 4) * 8)));
        chk("b2b_vld", dn_a.vld, 1);
        chk("b2b_frame", dn_a.frame, i % 4 == 0);
        chk("b2b_ready", tx_ready_a, i % 4 == 3);
      end else chk("b2b_idle", dn_a.vld, 0);
      chk("b2b_rx_valid", rx_valid_a, i == 4 || i == 8);
      if (i == 4) chk("b2b_rx_data0", rx_data_a, 32'h11223344);
      if (i == 8) chk("b2b_rx_data1", rx_data_a, 32'h55667788);
      if (i == 3) tx_data_a = 32'h55667788;
      if (i == 4) tx_valid_a = 1'b0;
      tick;
    end
    tx_valid_a = 1'b1;
    tx_data_a = 32'hCAFEF00D;
    tick;
    tx_valid_a = 1'b0;
    chk("rst_mid_b0", dn_a.lane, 8'h0D);
    tick;
    chk("rst_mid_b1", dn_a.lane, 8'hF0);
    rst_a = 1'b1;
    n0 = cnt_a;
    tick;
    rst_a = 1'b0;
    chk("rst_mid_vld", dn_a.vld, 0);
    chk("rst_mid_ready", tx_ready_a, 1);
    chk("rst_mid_rx", rx_valid_a, 0);
    repeat (6) tick;
    chk("rst_mid_no_strobe", cnt_a, n0);
    chk("rst_mid_dn_quiet", dn_a.vld, 0);
    chk("a_err_cnt", err_cnt_a, 0);
    tx_valid_b = 1'b1;
    tx_data_b = 20'hABCDE;
    tick;
    tx_valid_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("pad_lane", dn_b.lane, b_lane[k]);
      chk("pad_par", dn_b.par, b_par[k]);
      chk("pad_frame", dn_b.frame, k == 0);
      chk("pad_ready", tx_ready_b, k == 2);
      tick;
    end
    chk("pad_rx_valid", rx_valid_b, 1);
    chk("pad_rx_data", rx_data_b, 20'hABCDE);
    chk("pad_rx_perr", rx_perr_b, 0);
    lb_b = 1'b0;
    tick;
    beat(8'h45, 1'b1, 1'b0);
    beat(8'h23, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    chk("perr_rx_valid", rx_valid_b, 1);
    chk("perr_rx_data", rx_data_b, 20'h12345);
    chk("perr_rx_perr", rx_perr_b, 1);
    tick;
    chk("perr_err_cnt", err_cnt_b, 1);
    n0 = cnt_b;
    beat(8'h90, 1'b1, 1'b0);
    beat(8'h78, 1'b0, 1'b0);
    beat(8'h21, 1'b1, 1'b0);
    chk("abort_no_strobe", rx_valid_b, 0);
    beat(8'h43, 1'b0, 1'b0);
    beat(8'h05, 1'b0, 1'b0);
    chk("abort_rx_valid", rx_valid_b, 1);
    chk("abort_rx_data", rx_data_b, 20'h54321);
    chk("abort_rx_perr", rx_perr_b, 0);
    tick;
    chk("abort_err_cnt", err_cnt_b, 2);
    chk("abort_strobes", cnt_b, n0 + 1);
    n0 = cnt_b;
    beat(8'hDE, 1'b1, 1'b0);
    beat(8'hBC, 1'b0, 1'b0);
    repeat (3) tick;
    chk("gap_no_strobe", rx_valid_b, 0);
    beat(8'h0A, 1'b0, 1'b0);
    chk("gap_rx_valid", rx_valid_b, 1);
    chk("gap_rx_data", rx_data_b, 20'hABCDE);
    chk("gap_rx_perr", rx_perr_b, 0);
    repeat (3) tick;
    chk("gap_strobes", cnt_b, n0 + 1);
    chk("gap_hold", rx_data_b, 20'hABCDE);
    err_clr_b = 1'b1;
    tick;
    err_clr_b = 1'b0;
    chk("clr_err_cnt", err_cnt_b, 0);
    beat(8'h11, 1'b1, 1'b1);
    beat(8'h22, 1'b0, 1'b0);
    beat(8'h33, 1'b0, 1'b0);
    beat(8'h44, 1'b0, 1'b0);
    chk("dual_err_cnt", err_cnt_b, 2);
    err_clr_b = 1'b1;
    tick;
    err_clr_b = 1'b0;
    for (int w = 0; w < 5; w++) begin
      beat(8'h11, 1'b1, 1'b1);
      beat(8'h22, 1'b0, 1'b0);
      beat(8'h33, 1'b0, 1'b0);
    end
    repeat (2) tick;
    chk("sat_err_cnt", err_cnt_b, 3);
    err_clr_b = 1'b1;
    beat(8'hAA, 1'b0, 1'b0);
    err_clr_b = 1'b0;
    chk("clr_priority", err_cnt_b, 0);
    beat(8'hBB, 1'b0, 1'b0);
    chk("ferr_count", err_cnt_b, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/tsv_ser_link.md
Name: tsv_ser_link

Overview:
- Parametrised successor to the per-net TSV_CELL layer crossing.
- Instead of one TSV per signal, it serializes a DATA_W-bit word over TSV_W data TSVs plus valid, frame and parity TSVs.
- The TX half drives the DN-side lanes. The RX half receives the UP-side lanes and reassembles the word.
- Both halves run on clk1. Placed at every layer boundary of the 3D stack; the TSV lanes connect directly to TSV_CELL instances.

Parameters:
- DATA_W, 32: payload word width, ≥1.
- TSV_W, 8: data TSVs per direction, 1..DATA_W.
- ERR_W, 8: width of the saturating error counter.
- Derived: BEATS = ceil(DATA_W/TSV_W); BCNT_W = max(1, clog2(BEATS)).

Ports:
- clk1, in, 1: clock.
- rst1, in, 1: reset, synchronous, active-high.
- tx_valid, in, 1: TX word offered.
- tx_ready, out, 1: TX word accepted when tx_valid & tx_ready.
- tx_data, in, DATA_W: TX word.
- dn_lane, out, TSV_W: TX beat data.
- dn_vld, out, 1: TX beat valid.
- dn_frame, out, 1: marks beat 0.
- dn_par, out, 1: even parity over dn_lane.
- up_lane, in, TSV_W: RX beat data.
- up_vld, in, 1: RX beat valid.
- up_frame, in, 1: RX beat 0 marker.
- up_par, in, 1: RX beat parity.
- rx_valid, out, 1: one-cycle strobe, word complete.
- rx_data, out, DATA_W: reassembled word.
- rx_perr, out, 1: qualifies rx_valid; at least one beat of the word had a parity mismatch.
- err_cnt, out, ERR_W: saturating count of parity words plus frame errors.
- err_clr, in, 1: synchronous clear of err_cnt.

Behaviour:
- Clock and reset: one clock, clk1. Reset is rst1, synchronous and active-high.
- Reset values: all outputs 0 except tx_ready = 1. Both FSMs return to IDLE; any in-flight word is dropped, with no partial beat or strobe afterwards.
- Word padding: the word is zero-padded to BEATS*TSV_W bits. Beat k carries bits [k*TSV_W +: TSV_W]; beat 0 is the LSB chunk.
- TX FSM, states IDLE and SEND, with beat counter bcnt:
  - tx_ready = (IDLE) | (SEND & bcnt == BEATS-1).
  - Accept at cycle T: the word is captured, and the registered outputs present beat k in cycle T+1+k, k = 0..BEATS-1.
  - dn_vld = 1 and dn_par = ^dn_lane on every beat; dn_frame = 1 only on beat 0.
  - After the last beat: if a word was accepted in that same cycle, its beat 0 follows with no gap. Otherwise go to IDLE; dn_* = 0.
  - BEATS == 1: tx_ready is constantly 1 out of reset, and every accept produces one beat with frame = 1.
  - tx_data is sampled only at accept. tx_ready never depends on tx_valid combinationally.
- RX FSM, states IDLE and COLLECT, with beat counter rcnt:
  - up_* is sampled on the clk1 edge only when up_vld = 1. Cycles with up_vld = 0 are gaps: rcnt holds and the partial word is kept.
  - IDLE with vld & frame: store beat 0 and enter COLLECT with rcnt = 1.
  - IDLE with vld & !frame: discard the beat; frame error.
  - COLLECT with vld & !frame: store beat rcnt. If it is the last beat, register rx_data and rx_valid = 1 for one cycle, rx_perr = OR of per-beat mismatches, then go to IDLE.
  - COLLECT with vld & frame: frame error. Abort the partial word with no rx_valid and restart at beat 0 with this beat.
  - Latency: last beat sampled at edge E, so rx_valid is visible in the cycle after E. Loopback dn→up gives TX accept at T and rx_valid in cycle T+BEATS+1.
  - Padding bits are discarded. rx_data holds its value between strobes.
- err_cnt:
  - Increments by 1 per rx_valid with rx_perr and by 1 per frame error.
  - Both events in the same cycle count +2, saturating at 2^ERR_W-1.
  - err_clr has priority over increments in the same cycle.
- rst1 mid-word: on the next cycle dn_vld = 0, and RX discards the partial word.

Decomposition:
- Package tsv_link_pkg:
  - function beats(DATA_W, TSV_W);
  - typedef tx_state_e {IDLE, SEND};
  - typedef rx_state_e {IDLE, COLLECT};
  - function even_par.
- Sub-module tsv_ser_rx holds the RX FSM and error logic. The TX half stays in tsv_ser_link.

Test Plan:
- Loopback, DATA_W=32, TSV_W=8: accept 0xDEADBEEF at T → dn_lane 0xEF/BE/AD/DE in cycles T+1..T+4, frame only at T+1. rx_valid in cycle T+5, rx_data = 0xDEADBEEF, rx_perr = 0.
- Back-to-back words, tx_valid held high: 0x11223344 then 0x55667788 → 8 consecutive beats with no gap and frames at beats 0 and 4. Two rx_valid strobes 4 cycles apart.
- DATA_W=20, TSV_W=8 (BEATS=3): send 0xABCDE → beats 0xDE, 0xBC, 0x0A. Received word 0xABCDE, padding bits zero on the lanes.
- Flip up_par on beat 2 → rx_valid with rx_perr = 1 and err_cnt = 1. Then force frame = 1 on beat 2 of the next word → no rx_valid for the aborted word, err_cnt = 2, and the restarted word completes.
- RX gaps plus reset: drop up_vld for 3 cycles between beats 1 and 2 → word still correct. Assert rst1 after beat 1 of a TX word → the next cycle dn_vld = 0, tx_ready = 1, and no rx_valid.
- ERR_W=2: 5 parity errors → err_cnt saturates at 3. err_clr together with an error in the same cycle → err_cnt = 0.
